// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC/sqrt datapath family.
// Holds the default Q-format of the sqrt output, the 2-bit FSM state encoding
// used by the iterative blocks, and the rounding-constant helper.
package cordic_pkg;

  // Default sqrt output format: Q10.6 in a 16-bit word.
  localparam int unsigned CORDIC_WIDTH   = 16;
  localparam int unsigned CORDIC_F_WIDTH = 6;

  // Iterative FSM state encoding.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MULT  = 2'd1;
  localparam logic [1:0] ST_ROUND = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Half-LSB of a product carrying 2*f_width fraction bits (round half-up).
  function automatic logic [63:0] round_const(input int unsigned f_width);
    return 64'(1) << (2 * f_width - 1);
  endfunction

endpackage

// File: rtl/fixed_square_iter.sv
// fixed_square_iter: squares an unsigned Q(WIDTH-F_WIDTH).F_WIDTH root and
// returns round(root^2) as an unsigned WIDTH-bit integer, saturating on overflow.
// Radix-2 shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   sqrt_in, in_valid    operand and its valid
//   in_ready             high only in IDLE (and not in reset)
//   N_out, ovf           registered result and saturation flag
//   out_valid, out_ready result handshake; outputs held while stalled
module fixed_square_iter
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH   = CORDIC_WIDTH,
  parameter int unsigned F_WIDTH = CORDIC_F_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sqrt_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] N_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned SW    = 2 * WIDTH + 1;
  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [SW-1:0] RND = SW'(round_const(F_WIDTH));

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [PW-1:0]    a;
  logic [WIDTH-1:0] b;
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] cnt;

  logic             accept_c;
  logic             last_iter_c;
  logic [SW-1:0]    round_sum_c;
  logic [SW-1:0]    round_q_c;
  logic             sat_c;

  assign in_ready  = (state == ST_IDLE) & ~rst;
  assign out_valid = (state == ST_DONE);

  assign accept_c    = in_valid & in_ready;
  assign last_iter_c = (cnt == CNT_W'(WIDTH - 1));

  // Extra top bit keeps the carry out of the rounding add.
  assign round_sum_c = {1'b0, acc} + RND;
  assign round_q_c   = round_sum_c >> (2 * F_WIDTH);
  assign sat_c       = (round_q_c >> WIDTH) != '0;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept_c)    state_nxt = ST_MULT;
      ST_MULT:  if (last_iter_c) state_nxt = ST_ROUND;
      ST_ROUND:                  state_nxt = ST_DONE;
      ST_DONE:  if (out_ready)   state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  // Shift-add datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a     <= '0;
      b     <= '0;
      acc   <= '0;
      cnt   <= '0;
      N_out <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            a   <= PW'(sqrt_in);
            b   <= sqrt_in;
            acc <= '0;
            cnt <= '0;
          end
        end
        ST_MULT: begin
          // Full WIDTH iterations even when b runs out of ones: fixed latency.
          if (b[0]) acc <= acc + a;
          a   <= a << 1;
          b   <= b >> 1;
          cnt <= cnt + CNT_W'(1);
        end
        ST_ROUND: begin
          if (sat_c) begin
            N_out <= '1;
            ovf   <= 1'b1;
          end else begin
            N_out <= WIDTH'(round_q_c);
            ovf   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_square_iter.sv
// Self-checking bench for fixed_square_iter (WIDTH=16, F_WIDTH=6).
module tb_fixed_square_iter;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned LAT   = WIDTH + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sqrt_in;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] N_out;
  logic        out_valid;
  logic        out_ready;
  logic        ovf;

  fixed_square_iter #(.WIDTH(16), .F_WIDTH(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .sqrt_in   (sqrt_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .N_out     (N_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] n;
    logic        o;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   t0     = 0;
  int   xfers  = 0;
  logic prev_ov = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact square scaled by 2^-12, round half-up, saturate at 16 bits.
  function automatic exp_t model(input logic [15:0] x);
    longint unsigned sq;
    longint unsigned r;
    exp_t e;
    sq = longint'(x) * longint'(x);
    r  = (sq + 64'd2048) / 64'd4096;
    if (r >= 64'd65536) begin
      e.n = 16'hFFFF;
      e.o = 1'b1;
    end else begin
      e.n = 16'(r);
      e.o = 1'b0;
    end
    return e;
  endfunction

  // Transaction monitor: enqueue on accept, dequeue on result transfer.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready && q.size() > 0) begin
        void'(q.pop_front());
        xfers++;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(sqrt_in));
        t0 = cyc;
      end
    end
  end

  // Compare process: every cycle the result is presented.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid) begin
        if (q.size() == 0) chk("spurious_out_valid", 1, 0);
        else begin
          chk("n_out", N_out, q[0].n);
          chk("ovf", ovf, q[0].o);
        end
        chk("in_ready_busy", in_ready, 0);
        if (!prev_ov) chk("latency", cyc - t0, LAT);
      end
      prev_ov = out_valid;
    end
  end

  task automatic do_op(input logic [15:0] x, input int stall,
                       output logic [15:0] n, output logic o);
    int k;
    @(negedge clk);
    sqrt_in  = x;
    in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    if (!in_ready) chk("accept_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    sqrt_in  = 16'($urandom);
    k = 0;
    while (!out_valid && k < 200) begin @(negedge clk); k++; end
    if (!out_valid) chk("result_timeout", 0, 1);
    repeat (stall) @(negedge clk);
    n = N_out;
    o = ovf;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [15:0] dir_x [11] = '{16'h00C0, 16'h0060, 16'h0030, 16'h0020, 16'h00A0, 16'h002D,
                              16'h3FC0, 16'h4000, 16'hFFFF, 16'h0000, 16'h0100};
  logic [15:0] dir_n [11] = '{16'd9, 16'd2, 16'd1, 16'd0, 16'd6, 16'd0,
                              16'd65025, 16'hFFFF, 16'hFFFF, 16'd0, 16'd16};
  logic        dir_o [11] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};

  int rt_n [22] = '{0, 1, 2, 3, 4, 5, 10, 100, 255, 256, 1000, 4095, 4096, 10000,
                    32767, 32768, 50000, 65024, 65025, 65280, 65534, 65535};

  initial begin
    logic [15:0] n;
    logic        o;
    int          k;
    int          xb;
    exp_t        e;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sqrt_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_n_out", N_out, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    // Directed vectors with hand-computed results.
    for (int i = 0; i < 11; i++) begin
      e = model(dir_x[i]);
      chk("model_n", e.n, dir_n[i]);
      chk("model_ovf", e.o, dir_o[i]);
      do_op(dir_x[i], i % 3, n, o);
      chk("dir_n", n, dir_n[i]);
      chk("dir_ovf", o, dir_o[i]);
    end

    // Back-pressure: stall in DONE with a competing in_valid.
    @(negedge clk);
    sqrt_in = 16'h00C0; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 200) begin @(negedge clk); k++; end
    chk("bp_out_valid", out_valid, 1);
    sqrt_in = 16'h0060; in_valid = 1'b1;
    repeat (10) @(negedge clk);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_n", N_out, 9);
    chk("bp_no_accept", q.size(), 1);
    xb = xfers;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_one_xfer", xfers, xb + 1);
    chk("bp_valid_low", out_valid, 0);
    chk("bp_in_ready", in_ready, 1);
    chk("bp_n_kept", N_out, 9);

    // Reset in the middle of MULT (cnt == 7).
    @(negedge clk);
    sqrt_in = 16'h1234; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 100) begin @(negedge clk); k++; end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_n", N_out, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_op(16'h0100, 0, n, o);
    chk("post_rst_n", n, 16);
    chk("post_rst_ovf", o, 0);

    // Round-trip against an ideal sqrt quantised to the Q10.6 output.
    for (int i = 0; i < 42; i++) begin
      int    nv;
      real   root;
      real   tol;
      real   diff;
      logic [15:0] x;
      nv   = (i < 22) ? rt_n[i] : int'($urandom_range(65535, 0));
      root = $floor($sqrt(real'(nv)) * 64.0 + 0.5);
      if (root > 65535.0) root = 65535.0;
      x    = 16'(int'(root));
      do_op(x, 0, n, o);
      tol  = 2.0 * $sqrt(real'(nv)) / 64.0 + 1.0;
      diff = real'(int'(n)) - real'(nv);
      if (diff < 0.0) diff = -diff;
      checks++;
      if (diff > tol) begin
        errors++;
        $display("FAIL roundtrip N=%0d root=0x%0h: got %0d required within %f", nv, x, n, tol);
      end
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1);
  end

endmodule
